axis_packet_arbiter: RTL



---
 rtl/axis_arb_pkg.sv | 26 ++
 rtl/axis_arb_rr_select.sv | 57 +++++
 rtl/axis_packet_arbiter.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/axis_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : axis_arb_pkg
// Description : Shared state encoding and sizing helper for the AXI4-Stream
//               packet arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package axis_arb_pkg;

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_GRANT = 1'b1;

    // ceil(log2(n)), never below 1 so a 1-bit index always exists
    function automatic int clog2_min1(input int n);
        int r;
        r = 1;
        for (int i = 1; i < 32; i++) begin
            if ((1 << i) < n) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/axis_arb_rr_select.sv
`default_nettype none
// ============================================================================
// Module      : axis_arb_rr_select
// Description : Combinational round-robin priority encoder; picks the first
//               set request bit scanning from ptr upward, modulo S_COUNT.
// Revision    : 1.0 - initial release
// ============================================================================
module axis_arb_rr_select
    import axis_arb_pkg::*;
#(
    parameter int S_COUNT  = 4,
    parameter int ID_WIDTH = clog2_min1(S_COUNT)
) (
    input  logic [S_COUNT-1:0]  req,
    input  logic [ID_WIDTH-1:0] ptr,
    output logic                gnt_valid,
    output logic [ID_WIDTH-1:0] gnt_idx
);

    localparam logic [ID_WIDTH:0] c_s_count = (ID_WIDTH + 1)'(S_COUNT);

    logic [2*S_COUNT-1:0] w_req_dbl;
    logic [2*S_COUNT-1:0] w_req_shift;
    logic [S_COUNT-1:0]   w_rot;
    logic [ID_WIDTH-1:0]  w_off;
    logic                 w_any;
    logic [ID_WIDTH:0]    w_sum;

    // Rotating the doubled vector puts req[ptr] at bit 0
    assign w_req_dbl   = {req, req};
    assign w_req_shift = w_req_dbl >> ptr;
    assign w_rot       = w_req_shift[S_COUNT-1:0];

    always_comb begin
        w_off = '0;
        w_any = 1'b0;
        for (int j = S_COUNT - 1; j >= 0; j--) begin
            if (w_rot[j]) begin
                w_off = j[ID_WIDTH-1:0];
                w_any = 1'b1;
            end
        end
    end

    assign w_sum = {1'b0, ptr} + {1'b0, w_off};

    always_comb begin
        gnt_valid = w_any;
        if (w_sum >= c_s_count) begin
            gnt_idx = ID_WIDTH'(w_sum - c_s_count);
        end else begin
            gnt_idx = w_sum[ID_WIDTH-1:0];
        end
    end

endmodule
`default_nettype wire

// File: rtl/axis_packet_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : axis_packet_arbiter
// Description : Packet-granular round-robin arbiter sharing one AXI4-Stream
//               output among S_COUNT inputs; tid carries the source index.
// Revision    : 1.0 - initial release
// ============================================================================
module axis_packet_arbiter
    import axis_arb_pkg::*;
#(
    parameter int S_COUNT     = 4,
    parameter int DATA_WIDTH  = 8,
    parameter bit KEEP_ENABLE = (DATA_WIDTH > 8),
    parameter int KEEP_WIDTH  = DATA_WIDTH / 8,
    parameter int USER_WIDTH  = 1,
    parameter int ID_WIDTH    = clog2_min1(S_COUNT)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [S_COUNT-1:0]            enable,
    input  logic [S_COUNT*DATA_WIDTH-1:0] s_axis_tdata,
    input  logic [S_COUNT*KEEP_WIDTH-1:0] s_axis_tkeep,
    input  logic [S_COUNT-1:0]            s_axis_tvalid,
    output logic [S_COUNT-1:0]            s_axis_tready,
    input  logic [S_COUNT-1:0]            s_axis_tlast,
    input  logic [S_COUNT*USER_WIDTH-1:0] s_axis_tuser,
    output logic [DATA_WIDTH-1:0]         m_axis_tdata,
    output logic [KEEP_WIDTH-1:0]         m_axis_tkeep,
    output logic                          m_axis_tvalid,
    input  logic                          m_axis_tready,
    output logic                          m_axis_tlast,
    output logic [ID_WIDTH-1:0]           m_axis_tid,
    output logic [USER_WIDTH-1:0]         m_axis_tuser,
    output logic                          busy,
    output logic [ID_WIDTH-1:0]           grant_id
);

    localparam logic [ID_WIDTH-1:0] c_last_idx = ID_WIDTH'(S_COUNT - 1);

    logic [0:0]            r_state;
    logic [0:0]            w_state_next;
    logic [ID_WIDTH-1:0]   r_ptr;
    logic [ID_WIDTH-1:0]   r_grant_id;
    logic                  r_busy;
    logic                  r_m_tvalid;
    logic [DATA_WIDTH-1:0] r_m_tdata;
    logic [KEEP_WIDTH-1:0] r_m_tkeep;
    logic                  r_m_tlast;
    logic [ID_WIDTH-1:0]   r_m_tid;
    logic [USER_WIDTH-1:0] r_m_tuser;

    logic [S_COUNT-1:0]    w_req;
    logic                  w_sel_valid;
    logic [ID_WIDTH-1:0]   w_sel_idx;
    logic                  w_out_ready;
    logic                  w_hs;
    logic                  w_hs_last;
    logic [KEEP_WIDTH-1:0] w_keep;

    assign w_req       = s_axis_tvalid & enable;
    assign w_out_ready = !r_m_tvalid || m_axis_tready;
    assign w_hs        = (r_state == ST_GRANT) && w_out_ready && s_axis_tvalid[r_grant_id];
    assign w_hs_last   = w_hs && s_axis_tlast[r_grant_id];

    axis_arb_rr_select #(
        .S_COUNT  (S_COUNT),
        .ID_WIDTH (ID_WIDTH)
    ) u_rr_select (
        .req       (w_req),
        .ptr       (r_ptr),
        .gnt_valid (w_sel_valid),
        .gnt_idx   (w_sel_idx)
    );

    generate
        if (KEEP_ENABLE) begin : g_keep
            assign w_keep = s_axis_tkeep[r_grant_id*KEEP_WIDTH +: KEEP_WIDTH];
        end else begin : g_no_keep
            logic w_unused_keep;
            assign w_unused_keep = ^s_axis_tkeep;
            assign w_keep        = '1;
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_sel_valid) begin
                    w_state_next = ST_GRANT;
                end
            end
            ST_GRANT: begin
                if (w_hs_last) begin
                    w_state_next = ST_IDLE;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    // Only the granted input ever sees ready; everything else is held off
    always_comb begin
        s_axis_tready = '0;
        if (r_state == ST_GRANT) begin
            s_axis_tready[r_grant_id] = w_out_ready;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr      <= '0;
            r_grant_id <= '0;
            r_busy     <= 1'b0;
            r_m_tvalid <= 1'b0;
        end else begin
            if (r_state == ST_IDLE && w_sel_valid) begin
                r_grant_id <= w_sel_idx;
                r_busy     <= 1'b1;
            end
            if (w_hs_last) begin
                r_busy <= 1'b0;
                r_ptr  <= (r_grant_id == c_last_idx) ? '0 : r_grant_id + 1'b1;
            end
            if (w_hs) begin
                r_m_tvalid <= 1'b1;
            end else if (m_axis_tready) begin
                r_m_tvalid <= 1'b0;
            end
        end
    end

    // Payload fields are meaningless while tvalid is low, so they carry no reset
    always_ff @(posedge clk) begin
        if (w_hs) begin
            r_m_tdata <= s_axis_tdata[r_grant_id*DATA_WIDTH +: DATA_WIDTH];
            r_m_tkeep <= w_keep;
            r_m_tlast <= s_axis_tlast[r_grant_id];
            r_m_tid   <= r_grant_id;
            r_m_tuser <= s_axis_tuser[r_grant_id*USER_WIDTH +: USER_WIDTH];
        end
    end

    assign m_axis_tdata  = r_m_tdata;
    assign m_axis_tkeep  = r_m_tkeep;
    assign m_axis_tvalid = r_m_tvalid;
    assign m_axis_tlast  = r_m_tlast;
    assign m_axis_tid    = r_m_tid;
    assign m_axis_tuser  = r_m_tuser;
    assign busy          = r_busy;
    assign grant_id      = r_grant_id;

endmodule
`default_nettype wire
